// File: rtl/invaders_pkg.sv
// Shared constants and types for the invaders playfield blocks.
package invaders_pkg;

  localparam int ALIEN_W  = 30;
  localparam int ALIEN_H  = 20;
  localparam int PITCH_X  = 40;
  localparam int PITCH_Y  = 30;
  localparam int PLAYER_W = 30;
  localparam int BULLET_W = 4;
  localparam int BULLET_H = 8;

  typedef enum logic [1:0] {
    IDLE,
    MOVE,
    SCAN
  } state_t;

endpackage

// File: rtl/grid_hit_locator.sv
// Maps a bullet position onto the alien grid: reports whether the bullet's
// centre point lies inside an alien body and, if so, which cell it is.
module grid_hit_locator
  import invaders_pkg::*;
#(
  parameter int GRID_ROWS = 5,
  parameter int GRID_COLS = 10,
  parameter int IDX_W     = $clog2(GRID_ROWS * GRID_COLS)
) (
  input  logic [8:0]       row,
  input  logic [9:0]       col,
  input  logic [8:0]       origin_row,
  input  logic [9:0]       origin_col,
  output logic             in_cell,
  output logic [IDX_W-1:0] cell_index
);

  logic [10:0] x;
  logic [10:0] y;
  int unsigned xu;
  int unsigned yu;
  int unsigned cx;
  int unsigned cy;

  // Offset of the bullet centre from the grid origin; bit 10 is the sign.
  always_comb begin
    x  = {1'b0, col} + 11'(BULLET_W / 2) - {1'b0, origin_col};
    y  = {2'b00, row} + 11'(BULLET_H / 2) - {2'b00, origin_row};
    xu = 32'(x[9:0]);
    yu = 32'(y[9:0]);
    cx = xu / PITCH_X;
    cy = yu / PITCH_Y;
    in_cell = !x[10] && !y[10]
           && (xu < GRID_COLS * PITCH_X) && (yu < GRID_ROWS * PITCH_Y)
           && ((xu % PITCH_X) < ALIEN_W) && ((yu % PITCH_Y) < ALIEN_H);
    cell_index = IDX_W'(cy * GRID_COLS + cx);
  end

endmodule

// File: rtl/bullet_pool.sv
// Player bullet pool: up to NUM_SLOTS bullets, moved once per Tick and then
// tested against the alien grid one slot per clock.
// Optional feature: define BULLET_POOL_PIERCE_EN to let each bullet clear
// up to two aliens before it is retired.
module bullet_pool
  import invaders_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int GRID_ROWS = 5,
  parameter int GRID_COLS = 10,
  parameter int SPEED     = 20,
  parameter int COOLDOWN  = 8
) (
  input  logic                                  Clk,
  input  logic                                  Reset_n,
  input  logic                                  Tick,
  input  logic                                  Fire,
  input  logic [8:0]                            Player_Row,
  input  logic [9:0]                            Player_Col,
  input  logic [8:0]                            Aliens_Row,
  input  logic [9:0]                            Aliens_Col,
  output logic [NUM_SLOTS-1:0]                  Bullet_Active,
  output logic [9*NUM_SLOTS-1:0]                Bullet_Row,
  output logic [10*NUM_SLOTS-1:0]               Bullet_Col,
  output logic [GRID_ROWS*GRID_COLS-1:0]        Aliens_Grid,
  output logic                                  Aliens_Defeated,
  output logic                                  Fire_Ack,
  output logic                                  Collision,
  output logic [$clog2(GRID_ROWS*GRID_COLS)-1:0] Hit_Index
);

  localparam int CELLS  = GRID_ROWS * GRID_COLS;
  localparam int IDX_W  = $clog2(CELLS);
  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CD_W   = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  state_t              state;
  state_t              next_state;
  logic [SLOT_W-1:0]   scan_idx;
  logic [SLOT_W-1:0]   next_scan_idx;
  logic [NUM_SLOTS-1:0] active;
  logic [8:0]          slot_row [NUM_SLOTS];
  logic [9:0]          slot_col [NUM_SLOTS];
  logic [CELLS-1:0]    grid;
  logic [CD_W-1:0]     cooldown;
  logic                defeated;
  logic                reload;
  logic                fire_go;
  logic                free_found;
  logic [SLOT_W-1:0]   free_idx;
  logic                in_cell;
  logic [IDX_W-1:0]    cell_index;
  logic                scan_hit;
`ifdef BULLET_POOL_PIERCE_EN
  logic [NUM_SLOTS-1:0] pierced;
`endif

  assign defeated = (grid == '0);

  // Lowest-index free slot; the descending loop lets lower indices win.
  always_comb begin
    // NOTE: every comb output gets a default first so no latch is inferred.
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!active[i]) begin
        free_found = 1'b1;
        free_idx   = SLOT_W'(i);
      end
    end
  end

  // One shared locator, fed by whichever slot is currently being scanned.
  grid_hit_locator #(
    .GRID_ROWS (GRID_ROWS),
    .GRID_COLS (GRID_COLS),
    .IDX_W     (IDX_W)
  ) u_locator (
    .row        (slot_row[scan_idx]),
    .col        (slot_col[scan_idx]),
    .origin_row (Aliens_Row),
    .origin_col (Aliens_Col),
    .in_cell    (in_cell),
    .cell_index (cell_index)
  );

  assign scan_hit = (state == SCAN) && active[scan_idx] && in_cell && grid[cell_index];

  // Frame sequencer next-state logic; Tick beats Fire in the same IDLE cycle.
  always_comb begin
    next_state    = state;
    next_scan_idx = scan_idx;
    reload        = 1'b0;
    fire_go       = 1'b0;
    case (state)
      IDLE: begin
        if (Tick) begin
          if (defeated) reload = 1'b1;
          else          next_state = MOVE;
        end else if (Fire && (cooldown == '0) && free_found) begin
          fire_go = 1'b1;
        end
      end
      MOVE: begin
        next_state    = SCAN;
        next_scan_idx = '0;
      end
      SCAN: begin
        if (scan_idx == SLOT_W'(NUM_SLOTS - 1)) next_state = IDLE;
        else                                    next_scan_idx = scan_idx + SLOT_W'(1);
      end
      default: next_state = IDLE;
    endcase
  end

  // Frame sequencer state register.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (!Reset_n) begin
      state    <= IDLE;
      scan_idx <= '0;
    end else begin
      state    <= next_state;
      scan_idx <= next_scan_idx;
    end
  end

  // Slot, grid, cooldown and pulse registers.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      active    <= '0;
      // NOTE: the slot arrays are tiny and their reset values are visible
      // on the outputs, so they are reset explicitly rather than left as RAM.
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_row[i] <= '0;
        slot_col[i] <= '0;
      end
      grid      <= '1;
      cooldown  <= '0;
      Fire_Ack  <= 1'b0;
      Collision <= 1'b0;
      Hit_Index <= '0;
`ifdef BULLET_POOL_PIERCE_EN
      pierced   <= '0;
`endif
    end else begin
      Fire_Ack  <= fire_go;
      Collision <= 1'b0;

      if (Tick && (cooldown != '0)) cooldown <= cooldown - CD_W'(1);

      if (reload) begin
        grid   <= '1;
        active <= '0;
      end

      if (fire_go) begin
        active[free_idx]   <= 1'b1;
        slot_row[free_idx] <= Player_Row;
        slot_col[free_idx] <= Player_Col + 10'(PLAYER_W / 2);
        cooldown           <= CD_W'(COOLDOWN);
`ifdef BULLET_POOL_PIERCE_EN
        pierced[free_idx]  <= 1'b0;
`endif
      end

      if (state == MOVE) begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
          if (active[i]) begin
            if (slot_row[i] < 9'(SPEED)) active[i]   <= 1'b0;
            else                         slot_row[i] <= slot_row[i] - 9'(SPEED);
          end
        end
      end

      if (scan_hit) begin
        grid[cell_index] <= 1'b0;
        Collision        <= 1'b1;
        Hit_Index        <= cell_index;
`ifdef BULLET_POOL_PIERCE_EN
        if (pierced[scan_idx]) active[scan_idx]  <= 1'b0;
        else                   pierced[scan_idx] <= 1'b1;
`else
        active[scan_idx] <= 1'b0;
`endif
      end
    end
  end

  assign Bullet_Active   = active;
  assign Aliens_Grid     = grid;
  assign Aliens_Defeated = defeated;

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_flat
    assign Bullet_Row[9*i +: 9]   = slot_row[i];
    assign Bullet_Col[10*i +: 10] = slot_col[i];
  end

endmodule

// File: tb/tb_bullet_pool.sv
// Directed self-checking bench for bullet_pool (COOLDOWN overridden to 2).
module tb_bullet_pool;

  localparam int NS = 4;
  localparam int GR = 5;
  localparam int GC = 10;

  logic        clk = 1'b0;
  logic        Reset_n, Tick, Fire;
  logic [8:0]  Player_Row, Aliens_Row;
  logic [9:0]  Player_Col, Aliens_Col;
  logic [NS-1:0]      Bullet_Active;
  logic [9*NS-1:0]    Bullet_Row;
  logic [10*NS-1:0]   Bullet_Col;
  logic [GR*GC-1:0]   Aliens_Grid;
  logic               Aliens_Defeated, Fire_Ack, Collision;
  logic [5:0]         Hit_Index;

  int n_checks = 0;
  int n_fail   = 0;
  int ack_cnt  = 0;
  int coll_cnt = 0;
  logic [GR*GC-1:0] g_exp;

  always #5 clk = ~clk;

  bullet_pool #(
    .NUM_SLOTS (NS),
    .GRID_ROWS (GR),
    .GRID_COLS (GC),
    .SPEED     (20),
    .COOLDOWN  (2)
  ) dut (
    .Clk             (clk),
    .Reset_n         (Reset_n),
    .Tick            (Tick),
    .Fire            (Fire),
    .Player_Row      (Player_Row),
    .Player_Col      (Player_Col),
    .Aliens_Row      (Aliens_Row),
    .Aliens_Col      (Aliens_Col),
    .Bullet_Active   (Bullet_Active),
    .Bullet_Row      (Bullet_Row),
    .Bullet_Col      (Bullet_Col),
    .Aliens_Grid     (Aliens_Grid),
    .Aliens_Defeated (Aliens_Defeated),
    .Fire_Ack        (Fire_Ack),
    .Collision       (Collision),
    .Hit_Index       (Hit_Index)
  );

  // Pulse counters: read pre-edge values at each rising edge.
  always @(posedge clk) begin
    if (Fire_Ack)  ack_cnt  <= ack_cnt + 1;
    if (Collision) coll_cnt <= coll_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic fire_pulse();
    Fire = 1'b1;
    step(1);
    Fire = 1'b0;
    step(2);
  endtask

  task automatic do_tick();
    Tick = 1'b1;
    step(1);
    Tick = 1'b0;
    step(8);
  endtask

  initial begin
    Reset_n = 1'b0; Tick = 1'b0; Fire = 1'b0;
    Player_Row = '0; Player_Col = '0; Aliens_Row = '0; Aliens_Col = '0;
    step(2);
    Reset_n = 1'b1;
    step(1);

    // Reset state
    check("rst_active", Bullet_Active, 0);
    check("rst_rows", Bullet_Row, 0);
    check("rst_cols", Bullet_Col, 0);
    check("rst_grid", Aliens_Grid, {14'd0, {50{1'b1}}});
    check("rst_defeated", Aliens_Defeated, 0);
    check("rst_hit_index", Hit_Index, 0);
    check("rst_pulses", {Fire_Ack, Collision}, 0);

    // Single shot travelling up column 2 into the bottom row (cell 42)
    Aliens_Row = 9'd50; Aliens_Col = 10'd50;
    Player_Row = 9'd400; Player_Col = 10'd115;
    fire_pulse();
    check("shot_ack", ack_cnt, 1);
    check("shot_active", Bullet_Active, 4'b0001);
    check("shot_row", Bullet_Row[8:0], 400);
    check("shot_col", Bullet_Col[9:0], 130);
    repeat (10) do_tick();
    check("fly_no_coll", coll_cnt, 0);
    check("fly_row", Bullet_Row[8:0], 200);
    do_tick();
    check("hit_coll", coll_cnt, 1);
    check("hit_index", Hit_Index, 42);
    check("hit_grid_bit", Aliens_Grid[42], 0);
    check("hit_slot_off", Bullet_Active, 0);

    // Fire held outside the grid: cooldown spacing, then all slots busy
    Player_Col = 10'd500;
    Fire = 1'b1;
    step(3);
    check("held_ack1", ack_cnt, 2);
    check("held_col", Bullet_Col[9:0], 515);
    do_tick();
    check("cooldown_block", ack_cnt, 2);
    do_tick();
    check("cooldown_expire", ack_cnt, 3);
    check("held_active2", Bullet_Active, 4'b0011);
    repeat (4) do_tick();
    check("held_ack4", ack_cnt, 5);
    check("held_full", Bullet_Active, 4'b1111);
    repeat (13) do_tick();
    check("full_no_ack", ack_cnt, 5);
    check("row_at_speed", Bullet_Row[8:0], 20);
    do_tick();
    check("row_zero_alive", Bullet_Active, 4'b1111);
    check("row_zero", Bullet_Row[8:0], 0);
    check("slot1_row", Bullet_Row[17:9], 40);
    check("full_no_ack2", ack_cnt, 5);
    Fire = 1'b0;
    do_tick();
    check("off_top", Bullet_Active, 4'b1110);
    check("off_top_no_coll", coll_cnt, 1);
    Fire = 1'b1;
    step(3);
    Fire = 1'b0;
    step(1);
    check("refire_ack", ack_cnt, 6);
    check("refire_row", Bullet_Row[8:0], 400);
    check("hit_index_held", Hit_Index, 42);

    // Reset asserted in the middle of a scan
    Tick = 1'b1;
    step(1);
    Tick = 1'b0;
    step(2);
    Reset_n = 1'b0;
    step(1);
    check("mid_rst_active", Bullet_Active, 0);
    check("mid_rst_rows", Bullet_Row, 0);
    check("mid_rst_cols", Bullet_Col, 0);
    check("mid_rst_grid", Aliens_Grid, {14'd0, {50{1'b1}}});
    check("mid_rst_hit", Hit_Index, 0);
    check("mid_rst_pulses", {Fire_Ack, Collision}, 0);
    Reset_n = 1'b1;

    // FSM back in IDLE: a one-cycle Fire is accepted at once
    Player_Row = 9'd110; Player_Col = 10'd320; Aliens_Col = 10'd1000;
    fire_pulse();
    check("post_rst_ack", ack_cnt, 7);
    check("post_rst_row", Bullet_Row[8:0], 110);
    check("post_rst_col", Bullet_Col[9:0], 335);

    // Two slots in the same cell (cell 7): only slot 0 scores
    repeat (2) do_tick();
    Player_Row = 9'd70;
    fire_pulse();
    check("pair_ack", ack_cnt, 8);
    check("pair_active", Bullet_Active, 4'b0011);
    Aliens_Col = 10'd50;
    do_tick();
    g_exp = '1;
    g_exp[7] = 1'b0;
    check("pair_coll", coll_cnt, 2);
    check("pair_hit_index", Hit_Index, 7);
    check("pair_grid", Aliens_Grid, 64'(g_exp));
    check("pair_active_after", Bullet_Active, 4'b0010);
    check("pair_slot1_row", Bullet_Row[17:9], 50);

    // Clear the grid one cell at a time, steering the grid onto each shot
    Aliens_Col = 10'd1000;
    repeat (3) do_tick();
    check("drain", Bullet_Active, 0);
    Player_Row = 9'd300; Player_Col = 10'd500;
    for (int k = 49; k >= 1; k--) begin
      if (k != 7) begin
        Aliens_Col = 10'd1000;
        fire_pulse();
        Aliens_Row = 9'(279 - 30 * (k / 10));
        Aliens_Col = 10'(512 - 40 * (k % 10));
        do_tick();
        Aliens_Col = 10'd1000;
        do_tick();
      end
    end
    check("sweep_grid", Aliens_Grid, 1);
    check("sweep_coll", coll_cnt, 50);
    check("sweep_hit_index", Hit_Index, 1);
    check("sweep_not_defeated", Aliens_Defeated, 0);

    // Spare bullet stays in flight while the last alien is cleared
    fire_pulse();
    repeat (2) do_tick();
    fire_pulse();
    check("final_ack", ack_cnt, 58);
    Aliens_Row = 9'd279; Aliens_Col = 10'd512;
    do_tick();
    check("last_coll", coll_cnt, 51);
    check("last_grid", Aliens_Grid, 0);
    check("defeated", Aliens_Defeated, 1);
    check("last_active", Bullet_Active, 4'b0001);
    check("spare_row", Bullet_Row[8:0], 240);
    do_tick();
    check("reload_grid", Aliens_Grid, {14'd0, {50{1'b1}}});
    check("reload_slots", Bullet_Active, 0);
    check("reload_not_defeated", Aliens_Defeated, 0);
    check("reload_no_coll", coll_cnt, 51);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
